// File: rtl/regfile_wb_arb.sv
// rtl/regfile_wb_arb.sv - writeback arbiter for the regfile write port
// Source A has fixed priority; source B goes through an in-order queue with WAW kill.
module regfile_wb_arb #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 32,
  parameter  int QDEPTH = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_a_valid,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [AW-1:0]    i_b_addr,
  input  logic [WIDTH-1:0] i_b_data,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_wr_en,
  output logic [CW-1:0]    o_b_count,
  output logic [DEPTH-1:0] o_pend_mask
);

  logic [CW-1:0]    head;
  logic [CW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [QDEPTH-1:0] live;
  logic [AW-1:0]    q_addr [QDEPTH];
  logic [WIDTH-1:0] q_data [QDEPTH];

  logic [CW-2:0] head_idx;
  logic [CW-2:0] tail_idx;
  logic          push;
  logic          pop;
  logic          empty;
  logic          head_live;

  assign head_idx  = head[CW-2:0];
  assign tail_idx  = tail[CW-2:0];
  assign empty     = (count == '0);
  assign o_b_ready = rst_n && (count < CW'(QDEPTH));
  assign push      = i_b_valid && o_b_ready;
  // A and pop are exclusive, so the popped head can never be a kill target.
  assign pop       = !i_a_valid && !empty;
  assign head_live = live[head_idx];
  assign o_b_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      live      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      for (int i = 0; i < QDEPTH; i++) begin
        if (i_a_valid && live[i] && (q_addr[i] == i_a_addr)) live[i] <= 1'b0;
      end
      if (pop)  live[head_idx] <= 1'b0;
      // Written last so a same-cycle B entry survives a matching A write.
      if (push) live[tail_idx] <= 1'b1;

      if (i_a_valid) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= i_a_addr;
        o_wr_data <= i_a_data;
      end else if (!empty && head_live) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= q_addr[head_idx];
        o_wr_data <= q_data[head_idx];
      end else begin
        o_wr_en   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail_idx] <= i_b_addr;
      q_data[tail_idx] <= i_b_data;
    end
  end

  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (live[i]) o_pend_mask[q_addr[i]] = 1'b1;
    end
  end

endmodule
